info_reg_slave: RTL and testbench
=================================

# info_reg_slave

Read-mostly register slave that exposes the build-information set (major version, minor version, git hash) plus a scratch register, a 64-bit uptime counter and a fixed ID word over a simple valid/ready request/response bus. It sits directly downstream of the shared `top_lib` package: it consumes `MAJ_VER`, `MIN_VER`, `GIT_HSH` and the `sreg`/`dreg` types and makes them readable by the host-side bus master or debug bridge.

## Interface
- `ADDR_WIDTH`, 4: word-address width; only addresses 0–6 are mapped.
- `ID_WORD`, 32'h534E_4553 ("SNES"): constant returned at address 6.
- `clkIn` in 1: single clock for all logic.
- `rstIn` in 1: synchronous, active-high reset.
- `reqValidIn` in 1: request present.
- `reqReadyOut` out 1: slave can accept a request this cycle.
- `reqWriteIn` in 1: 1 = write, 0 = read.
- `reqAddrIn` in ADDR_WIDTH: word address.
- `reqDataIn` in 32: write data.
- `rspValidOut` out 1: response present.
- `rspReadyIn` in 1: master accepts the response.
- `rspDataOut` out 32 (`sreg`): read data; 0 for writes and errors.
- `rspErrOut` out 1: unmapped address, or write to a read-only register.

## Operation
- Register map (word address):
  - 0: majVer (RO) = `MAJ_VER`
  - 1: minVer (RO) = `MIN_VER`
  - 2: gitHash (RO) = `GIT_HSH`
  - 3: scratch (RW), reset 0
  - 4: uptime[31:0] (RO)
  - 5: uptime[63:32] snapshot (RO)
  - 6: `ID_WORD` (RO)
  - 7 and above: unmapped → `rspErrOut`=1, data 0.
- Handshake: a request is accepted on a rising edge where `reqValidIn && reqReadyOut`. A response is consumed on an edge where `rspValidOut && rspReadyIn`.
- `reqReadyOut = !rspValidOut || rspReadyIn` (combinational). This is a one-deep response buffer, so back-to-back throughput is one transaction per cycle.
- States:
  - EMPTY (`rspValidOut`=0)
  - FULL (`rspValidOut`=1)
- Transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on consume with no new accept.
  - FULL → FULL on simultaneous consume and accept; the response registers take the new transaction.
  - While FULL and `rspReadyIn`=0: `rspDataOut`/`rspErrOut` hold stable and `reqReadyOut`=0.
- Writes:
  - Address 3 updates scratch on the accept edge; the response has data 0, err 0.
  - Writes to any other address have no state effect; the response has err 1.
- Uptime:
  - `dreg` counter, increments every non-reset cycle, wraps 2^64−1 → 0.
  - A read of address 4 returns counter[31:0] as sampled in the accept cycle (pre-increment value). On the same edge it latches counter[63:32] into the snapshot.
  - A read of address 5 returns the snapshot, not the live value. Snapshot reset value is 0.
- Reset:
  - Outputs: `rspValidOut`=0, `rspDataOut`=0, `rspErrOut`=0, `reqReadyOut`=1.
  - State: scratch=0, counter=0, snapshot=0.
  - A pending response is dropped without being consumed.
  - Requests presented while `rstIn`=1 are not accepted.

## Timing
- Latency: accept on edge N → `rspValidOut`=1 and data valid after edge N, i.e. in cycle N+1.
- A scratch write accepted on edge N is visible to a read accepted on edge N+1 or later.
- Counter: 0 in the first cycle after `rstIn` deasserts, then +1 per cycle.
- No combinational path from `reqValidIn`/`reqAddrIn` to the `rsp*` outputs. `rspReadyIn` → `reqReadyOut` is the only combinational path.

## Structure
- Add to `top_lib`:
  - `ID_WORD` constant.
  - Address constants `ADDR_MAJ`…`ADDR_ID`.
  - A `rsp_t` struct {sreg data; logic err;}.
- Natural sub-module: `uptime_counter` (64-bit counter with snapshot-on-read-low strobe and snapshot output).
- Decode and response buffer live in `info_reg_slave`.

## Test plan
- Reset, then read addresses 0, 1, 2, 6 with `rspReadyIn`=1 → `MAJ_VER`, `MIN_VER`, `GIT_HSH`, 0x534E4553; err 0; each response one cycle after accept.
- Write 0xDEADBEEF to address 3, read address 3 on the next cycle → 0xDEADBEEF, err 0. Then assert reset and read again → 0.
- Write to address 0 and read address 9 → both err 1, data 0; address 0 still reads `MAJ_VER`.
- Hold `rspReadyIn`=0 for 5 cycles with `reqValidIn`=1 → `reqReadyOut`=0 and the response holds stable. Release → the next request is accepted on the same edge as the consume; back-to-back streaming sustains 1 transaction per cycle.
- Force the counter to 0x0000_0000_FFFF_FFFF, read address 4 then address 5 → 0xFFFFFFFF then 0x00000000 (snapshot), not the post-carry live value of 1.
- Accept a read, assert `rstIn` while `rspValidOut`=1 → `rspValidOut`=0 on the next edge and the response is never observed.

Source files
------------

// File: rtl/top_lib.sv
// Shared build-information constants and register types used by the info register slave.
package top_lib;

    typedef logic [31:0] sreg;
    typedef logic [63:0] dreg;

    localparam sreg MAJ_VER = 32'd2;
    localparam sreg MIN_VER = 32'd7;
    localparam sreg GIT_HSH = 32'h9F3C_A1D5;
    localparam sreg ID_WORD = 32'h534E_4553;

    localparam sreg ADDR_MAJ     = 32'd0;
    localparam sreg ADDR_MIN     = 32'd1;
    localparam sreg ADDR_GIT     = 32'd2;
    localparam sreg ADDR_SCRATCH = 32'd3;
    localparam sreg ADDR_UP_LO   = 32'd4;
    localparam sreg ADDR_UP_HI   = 32'd5;
    localparam sreg ADDR_ID      = 32'd6;

    typedef struct packed {
        sreg  data;
        logic err;
    } rsp_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/info_reg_slave_uptime.sv
// 64-bit free-running uptime counter; a read-low strobe captures the upper word
// so the host can assemble a coherent 64-bit value from two 32-bit reads.
module uptime_counter
    import top_lib::*;
(
    input  logic clk,
    input  logic rst,
    input  logic snap,
    output sreg  count_lo,
    output sreg  snapshot
);

    dreg cnt;
    sreg snap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            snap_q <= '0;
        end else begin
            cnt <= cnt + 64'd1;
            if (snap) begin
                snap_q <= cnt[63:32];
            end
        end
    end

    assign count_lo = cnt[31:0];
    assign snapshot = snap_q;

endmodule

// File: rtl/info_reg_slave.sv
// Read-mostly build-info register slave on a valid/ready request/response bus
// with a one-deep registered response buffer.
module info_reg_slave
    import top_lib::*;
#(
    parameter int  ADDR_WIDTH = 4,
    parameter sreg ID_WORD    = top_lib::ID_WORD
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  reqValidIn,
    output logic                  reqReadyOut,
    input  logic                  reqWriteIn,
    input  logic [ADDR_WIDTH-1:0] reqAddrIn,
    input  logic [31:0]           reqDataIn,
    output logic                  rspValidOut,
    input  logic                  rspReadyIn,
    output sreg                   rspDataOut,
    output logic                  rspErrOut
);

    buf_state_t state, state_next;
    rsp_t       rsp_next, rsp_p1;
    sreg        scratch;
    sreg        addr_ext;
    sreg        up_lo;
    sreg        up_hi_snap;
    logic       accept;
    logic       consume;
    logic       snap;

    assign addr_ext    = 32'(reqAddrIn);
    assign rspValidOut = (state == FULL);
    assign reqReadyOut = !rspValidOut || rspReadyIn;
    assign accept      = reqValidIn && reqReadyOut && !rstIn;
    assign consume     = rspValidOut && rspReadyIn;
    assign snap        = accept && !reqWriteIn && (addr_ext == ADDR_UP_LO);

    uptime_counter u_uptime (
        .clk      (clkIn),
        .rst      (rstIn),
        .snap     (snap),
        .count_lo (up_lo),
        .snapshot (up_hi_snap)
    );

    // Request decode: everything here is registered before reaching the rsp outputs.
    always_comb begin
        rsp_next = '0;
        if (reqWriteIn) begin
            rsp_next.err = (addr_ext != ADDR_SCRATCH);
        end else begin
            case (addr_ext)
                ADDR_MAJ:     rsp_next.data = MAJ_VER;
                ADDR_MIN:     rsp_next.data = MIN_VER;
                ADDR_GIT:     rsp_next.data = GIT_HSH;
                ADDR_SCRATCH: rsp_next.data = scratch;
                ADDR_UP_LO:   rsp_next.data = up_lo;
                ADDR_UP_HI:   rsp_next.data = up_hi_snap;
                ADDR_ID:      rsp_next.data = ID_WORD;
                default:      rsp_next.err  = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (consume && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Response stage: loads only on accept, so it holds stable under backpressure.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            rsp_p1 <= '0;
        end else if (accept) begin
            rsp_p1 <= rsp_next;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            scratch <= '0;
        end else if (accept && reqWriteIn && (addr_ext == ADDR_SCRATCH)) begin
            scratch <= reqDataIn;
        end
    end

    assign rspDataOut = rsp_p1.data;
    assign rspErrOut  = rsp_p1.err;

endmodule

// File: tb/tb_info_reg_slave.sv
// Directed self-checking bench for info_reg_slave.
module tb_info_reg_slave;
    import top_lib::*;

    logic       clk;
    logic       rstIn;
    logic       reqValidIn;
    logic       reqReadyOut;
    logic       reqWriteIn;
    logic [3:0] reqAddrIn;
    logic [31:0] reqDataIn;
    logic       rspValidOut;
    logic       rspReadyIn;
    logic [31:0] rspDataOut;
    logic       rspErrOut;

    int checks = 0;
    int errors = 0;

    info_reg_slave #(
        .ADDR_WIDTH (4),
        .ID_WORD    (32'h534E_4553)
    ) dut (
        .clkIn       (clk),
        .rstIn       (rstIn),
        .reqValidIn  (reqValidIn),
        .reqReadyOut (reqReadyOut),
        .reqWriteIn  (reqWriteIn),
        .reqAddrIn   (reqAddrIn),
        .reqDataIn   (reqDataIn),
        .rspValidOut (rspValidOut),
        .rspReadyIn  (rspReadyIn),
        .rspDataOut  (rspDataOut),
        .rspErrOut   (rspErrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One request presented for one edge; caller keeps rspReadyIn=1 so it is accepted.
    task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d);
        reqValidIn = 1'b1;
        reqWriteIn = w;
        reqAddrIn  = a;
        reqDataIn  = d;
        @(posedge clk);
        #1;
        reqValidIn = 1'b0;
        reqWriteIn = 1'b0;
        reqAddrIn  = '0;
        reqDataIn  = '0;
    endtask

    task automatic test_reset();
        rstIn = 1'b1; rspReadyIn = 1'b1;
        reqValidIn = 1'b1; reqWriteIn = 1'b0; reqAddrIn = 4'd0; reqDataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rspValidOut); end
        checks++; if (rspDataOut !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", rspDataOut); end
        checks++; if (rspErrOut !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rspErrOut); end
        checks++; if (reqReadyOut !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", reqReadyOut); end
        reqValidIn = 1'b0;
        rstIn = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b want 0", rspValidOut); end
    endtask

    task automatic test_ro_reads();
        logic [3:0] addrs [4] = '{4'd0, 4'd1, 4'd2, 4'd6};
        logic [31:0] exp  [4] = '{MAJ_VER, MIN_VER, GIT_HSH, 32'h534E_4553};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], 32'h0);
            checks++; if (rspValidOut !== 1'b1) begin errors++; $display("FAIL ro_valid[%0d]: got %b want 1", i, rspValidOut); end
            checks++; if (rspDataOut !== exp[i]) begin errors++; $display("FAIL ro_data[%0d]: got %h want %h", i, rspDataOut, exp[i]); end
            checks++; if (rspErrOut !== 1'b0) begin errors++; $display("FAIL ro_err[%0d]: got %b want 0", i, rspErrOut); end
        end
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0) begin errors++; $display("FAIL ro_drain: got %b want 0", rspValidOut); end
    endtask

    task automatic test_scratch();
        issue(1'b1, 4'd3, 32'hDEAD_BEEF);
        checks++; if (rspDataOut !== 32'h0 || rspErrOut !== 1'b0) begin errors++; $display("FAIL scr_wr_rsp: got %h/%b want 00000000/0", rspDataOut, rspErrOut); end
        issue(1'b0, 4'd3, 32'h0);
        checks++; if (rspDataOut !== 32'hDEAD_BEEF || rspErrOut !== 1'b0) begin errors++; $display("FAIL scr_rd: got %h/%b want deadbeef/0", rspDataOut, rspErrOut); end
        rstIn = 1'b1;
        @(posedge clk);
        #1;
        rstIn = 1'b0;
        issue(1'b0, 4'd3, 32'h0);
        checks++; if (rspDataOut !== 32'h0 || rspValidOut !== 1'b1) begin errors++; $display("FAIL scr_after_reset: got %h/v%b want 00000000/v1", rspDataOut, rspValidOut); end
    endtask

    task automatic test_errors();
        issue(1'b1, 4'd0, 32'h1234_5678);
        checks++; if (rspErrOut !== 1'b1 || rspDataOut !== 32'h0) begin errors++; $display("FAIL err_wr_ro: got %h/%b want 00000000/1", rspDataOut, rspErrOut); end
        issue(1'b0, 4'd9, 32'h0);
        checks++; if (rspErrOut !== 1'b1 || rspDataOut !== 32'h0) begin errors++; $display("FAIL err_rd_9: got %h/%b want 00000000/1", rspDataOut, rspErrOut); end
        issue(1'b0, 4'd7, 32'h0);
        checks++; if (rspErrOut !== 1'b1 || rspDataOut !== 32'h0) begin errors++; $display("FAIL err_rd_7: got %h/%b want 00000000/1", rspDataOut, rspErrOut); end
        issue(1'b1, 4'd5, 32'hFFFF_FFFF);
        checks++; if (rspErrOut !== 1'b1 || rspDataOut !== 32'h0) begin errors++; $display("FAIL err_wr_5: got %h/%b want 00000000/1", rspDataOut, rspErrOut); end
        issue(1'b0, 4'd0, 32'h0);
        checks++; if (rspErrOut !== 1'b0 || rspDataOut !== MAJ_VER) begin errors++; $display("FAIL err_maj_intact: got %h/%b want %h/0", rspDataOut, rspErrOut, MAJ_VER); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [3] = '{4'd6, 4'd0, 4'd1};
        logic [31:0] exp [3] = '{32'h534E_4553, MAJ_VER, MIN_VER};
        issue(1'b0, 4'd1, 32'h0);
        rspReadyIn = 1'b0;
        reqValidIn = 1'b1; reqWriteIn = 1'b0; reqAddrIn = 4'd2;
        #1;
        checks++; if (reqReadyOut !== 1'b0) begin errors++; $display("FAIL bp_ready_comb: got %b want 0", reqReadyOut); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (reqReadyOut !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, reqReadyOut); end
            checks++; if (rspValidOut !== 1'b1 || rspDataOut !== MIN_VER || rspErrOut !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got v%b %h/%b want v1 %h/0", i, rspValidOut, rspDataOut, rspErrOut, MIN_VER); end
        end
        rspReadyIn = 1'b1;
        #1;
        checks++; if (reqReadyOut !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", reqReadyOut); end
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b1 || rspDataOut !== GIT_HSH) begin errors++; $display("FAIL bp_release_data: got v%b %h want v1 %h", rspValidOut, rspDataOut, GIT_HSH); end
        for (int i = 0; i < 3; i++) begin
            reqAddrIn = seq[i];
            @(posedge clk);
            #1;
            checks++; if (rspValidOut !== 1'b1 || rspDataOut !== exp[i]) begin errors++; $display("FAIL stream[%0d]: got v%b %h want v1 %h", i, rspValidOut, rspDataOut, exp[i]); end
        end
        reqValidIn = 1'b0;
        reqAddrIn  = '0;
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", rspValidOut); end
    endtask

    task automatic test_uptime();
        rstIn = 1'b1;
        @(posedge clk);
        #1;
        rstIn = 1'b0;
        issue(1'b0, 4'd4, 32'h0);
        checks++; if (rspDataOut !== 32'd0) begin errors++; $display("FAIL up_first: got %h want 00000000", rspDataOut); end
        issue(1'b0, 4'd4, 32'h0);
        checks++; if (rspDataOut !== 32'd1) begin errors++; $display("FAIL up_second: got %h want 00000001", rspDataOut); end
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 4'd4, 32'h0);
        checks++; if (rspDataOut !== 32'd5) begin errors++; $display("FAIL up_idle: got %h want 00000005", rspDataOut); end

        reqValidIn = 1'b1; reqWriteIn = 1'b0; reqAddrIn = 4'd4;
        @(negedge clk);
        force dut.u_uptime.cnt = 64'h0000_0005_0000_0010;
        @(posedge clk);
        #1;
        release dut.u_uptime.cnt;
        reqValidIn = 1'b0; reqAddrIn = '0;
        checks++; if (rspDataOut !== 32'h0000_0010) begin errors++; $display("FAIL up_lo_a: got %h want 00000010", rspDataOut); end
        issue(1'b0, 4'd5, 32'h0);
        checks++; if (rspDataOut !== 32'h0000_0005) begin errors++; $display("FAIL up_hi_a: got %h want 00000005", rspDataOut); end

        reqValidIn = 1'b1; reqWriteIn = 1'b0; reqAddrIn = 4'd4;
        @(negedge clk);
        force dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_uptime.cnt;
        reqValidIn = 1'b0; reqAddrIn = '0;
        checks++; if (rspDataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL up_lo_carry: got %h want ffffffff", rspDataOut); end
        issue(1'b0, 4'd5, 32'h0);
        checks++; if (rspDataOut !== 32'h0000_0000) begin errors++; $display("FAIL up_hi_snapshot: got %h want 00000000", rspDataOut); end
    endtask

    task automatic test_reset_pending();
        issue(1'b0, 4'd0, 32'h0);
        checks++; if (rspValidOut !== 1'b1 || rspDataOut !== MAJ_VER) begin errors++; $display("FAIL rp_before: got v%b %h want v1 %h", rspValidOut, rspDataOut, MAJ_VER); end
        rstIn = 1'b1;
        rspReadyIn = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0 || rspDataOut !== 32'h0 || rspErrOut !== 1'b0) begin errors++; $display("FAIL rp_dropped: got v%b %h/%b want v0 00000000/0", rspValidOut, rspDataOut, rspErrOut); end
        checks++; if (reqReadyOut !== 1'b1) begin errors++; $display("FAIL rp_ready: got %b want 1", reqReadyOut); end
        rstIn = 1'b0;
        rspReadyIn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rspValidOut !== 1'b0) begin errors++; $display("FAIL rp_after: got %b want 0", rspValidOut); end
    endtask

    initial begin
        test_reset();
        test_ro_reads();
        test_scratch();
        test_errors();
        test_back_to_back();
        test_uptime();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
